// File: rtl/narrow_pkg.sv
// Shared widths, saturation limits and the narrowed-entry payload for narrow_sat16.
// narrow_word() holds the fit test and the clamp/truncate choice.
package narrow_pkg;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;

    localparam logic [OUT_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [OUT_W-1:0] SAT_MIN = 16'h8000;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             ovf;
    } narrow_entry_t;

    // A word fits when bits [IN_W-1:OUT_W-1] are all copies of the sign bit.
    function automatic narrow_entry_t narrow_word(input logic [IN_W-1:0] w, input logic sat);
        narrow_entry_t e;
        logic          fit;
        fit    = (&w[IN_W-1:OUT_W-1]) | ~(|w[IN_W-1:OUT_W-1]);
        e.ovf  = ~fit;
        e.data = w[OUT_W-1:0];
        if (!fit && sat) begin
            e.data = w[IN_W-1] ? SAT_MIN : SAT_MAX;
        end
        return e;
    endfunction

endpackage

// File: rtl/narrow_sat16_if.sv
// Valid/ready stream bundle for narrow_sat16: 32-bit input side, 16-bit output side.
interface narrow_sat16_if;
    import narrow_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    // Driven by the word producer and the halfword consumer.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf
    );

    // Driven by the narrowing stage.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf
    );

endinterface

// File: rtl/narrow_sat16_fifo2.sv
// Two-entry synchronous FIFO of narrowed entries; head is presented straight from storage.
module narrow_sat16_fifo2
    import narrow_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  narrow_entry_t push_entry,
    input  logic          pop,
    output narrow_entry_t head,
    output logic [1:0]    count
);

    localparam int unsigned DEPTH = 2;

    narrow_entry_t r_mem [DEPTH];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // Guard against overrun/underrun even if the caller misbehaves.
    assign w_do_push = push & (r_count != 2'(DEPTH));
    assign w_do_pop  = pop  & (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/narrow_sat16.sv
// 32->16 narrowing stage: fit test, clamp or truncate, 2-entry output buffer,
// and sticky/saturating overflow status.
module narrow_sat16
    import narrow_pkg::*;
#(
    parameter bit          SAT   = 1'b1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    narrow_sat16_if.slave    bus,
    input  logic             clr_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    narrow_entry_t    w_entry;
    narrow_entry_t    w_head;
    logic [1:0]       w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_push;

    logic             r_ovf_sticky;
    logic [CNT_W-1:0] r_ovf_count;

    assign w_entry    = narrow_word(bus.in_data, SAT);
    assign w_push     = bus.in_valid & bus.in_ready;
    assign w_pop      = bus.out_valid & bus.out_ready;
    assign w_ovf_push = w_push & w_entry.ovf;

    narrow_sat16_fifo2 u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count)
    );

    // Ready depends only on buffer occupancy, never on out_ready; held low during reset.
    assign bus.in_ready  = ~reset & (w_count != 2'd2);
    assign bus.out_valid = (w_count != 2'd0);
    assign bus.out_data  = w_head.data;
    assign bus.out_ovf   = w_head.ovf;

    // A new overflow in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_count  <= '0;
        end else if (w_ovf_push) begin
            r_ovf_sticky <= 1'b1;
            if (clr_ovf) begin
                r_ovf_count <= CNT_W'(1);
            end else if (r_ovf_count != CNT_MAX) begin
                r_ovf_count <= r_ovf_count + CNT_W'(1);
            end
        end else if (clr_ovf) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_count  <= '0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
    assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_narrow_sat16.sv
// Directed bench for narrow_sat16: a saturating instance (u_sat) and a truncating one (u_trn).
module tb_narrow_sat16;

    logic       clk;
    logic       reset;
    logic       clr_s;
    logic       clr_t;
    logic       stk_s;
    logic       stk_t;
    logic [7:0] cnt_s;
    logic [7:0] cnt_t;

    int vectors;
    int miscompares;

    narrow_sat16_if bs ();
    narrow_sat16_if bt ();

    narrow_sat16 #(.SAT(1'b1), .CNT_W(8)) u_sat (
        .clk(clk), .reset(reset), .bus(bs), .clr_ovf(clr_s),
        .ovf_sticky(stk_s), .ovf_count(cnt_s)
    );

    narrow_sat16 #(.SAT(1'b0), .CNT_W(8)) u_trn (
        .clk(clk), .reset(reset), .bus(bt), .clr_ovf(clr_t),
        .ovf_sticky(stk_t), .ovf_count(cnt_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic o);
        chk({tag, ".valid"}, 32'(bs.out_valid), 32'(v));
        chk({tag, ".data"},  32'(bs.out_data),  32'(d));
        chk({tag, ".ovf"},   32'(bs.out_ovf),   32'(o));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        clr_s = 1'b0;
        clr_t = 1'b0;
        bs.in_valid = 1'b0; bs.in_data = '0; bs.out_ready = 1'b1;
        bt.in_valid = 1'b0; bt.in_data = '0; bt.out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst.in_ready", 32'(bs.in_ready), 32'd0);
        chk_out("rst", 1'b0, 16'h0000, 1'b0);
        chk("rst.sticky", 32'(stk_s), 32'd0);
        chk("rst.count",  32'(cnt_s), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(bs.in_ready), 32'd1);

        // In-range words, one per cycle, one-cycle latency
        bs.in_valid = 1'b1; bs.in_data = 32'h0000_1234;
        tick(); chk_out("fit0", 1'b1, 16'h1234, 1'b0);
        bs.in_data = 32'hFFFF_8000;
        tick(); chk_out("fit1", 1'b1, 16'h8000, 1'b0);
        bs.in_data = 32'h0000_7FFF;
        tick(); chk_out("fit2", 1'b1, 16'h7FFF, 1'b0);
        bs.in_valid = 1'b0;
        tick(); chk("fit.drain", 32'(bs.out_valid), 32'd0);
        chk("fit.count", 32'(cnt_s), 32'd0);
        chk("fit.sticky", 32'(stk_s), 32'd0);

        // Saturation on both sides
        bs.in_valid = 1'b1; bs.in_data = 32'h0000_8000;
        tick(); chk_out("satp", 1'b1, 16'h7FFF, 1'b1);
        bs.in_data = 32'hFFFF_7FFF;
        tick(); chk_out("satn", 1'b1, 16'h8000, 1'b1);
        bs.in_valid = 1'b0;
        tick();
        chk("sat.sticky", 32'(stk_s), 32'd1);
        chk("sat.count",  32'(cnt_s), 32'd2);

        // Truncating instance
        bt.in_valid = 1'b1; bt.in_data = 32'h0001_2345;
        tick();
        chk("trn.valid", 32'(bt.out_valid), 32'd1);
        chk("trn.data",  32'(bt.out_data),  32'h2345);
        chk("trn.ovf",   32'(bt.out_ovf),   32'd1);
        chk("trn.count", 32'(cnt_t), 32'd1);
        chk("trn.sticky", 32'(stk_t), 32'd1);
        bt.in_valid = 1'b0;

        // Clear alone
        clr_s = 1'b1;
        tick(); clr_s = 1'b0;
        chk("clr.sticky", 32'(stk_s), 32'd0);
        chk("clr.count",  32'(cnt_s), 32'd0);

        // Backpressure: third word held until the buffer frees
        bs.out_ready = 1'b0;
        bs.in_valid = 1'b1; bs.in_data = 32'h0000_0011;
        tick(); chk_out("bp.a", 1'b1, 16'h0011, 1'b0);
        chk("bp.rdy1", 32'(bs.in_ready), 32'd1);
        bs.in_data = 32'h0000_0022;
        tick(); chk_out("bp.a_hold", 1'b1, 16'h0011, 1'b0);
        chk("bp.rdy2", 32'(bs.in_ready), 32'd0);
        bs.in_data = 32'h0000_0033;
        tick(); chk_out("bp.a_hold2", 1'b1, 16'h0011, 1'b0);
        chk("bp.rdy3", 32'(bs.in_ready), 32'd0);
        bs.out_ready = 1'b1;
        tick(); chk_out("bp.b", 1'b1, 16'h0022, 1'b0);
        chk("bp.rdy4", 32'(bs.in_ready), 32'd1);
        tick(); chk_out("bp.c", 1'b1, 16'h0033, 1'b0);
        bs.in_valid = 1'b0;
        tick(); chk("bp.empty", 32'(bs.out_valid), 32'd0);

        // Build count to 5, then overflow push coinciding with clear
        bs.in_valid = 1'b1; bs.in_data = 32'h0001_0000;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt5", 32'(cnt_s), 32'd5);
        clr_s = 1'b1;
        tick();
        chk("clrpush.count",  32'(cnt_s), 32'd1);
        chk("clrpush.sticky", 32'(stk_s), 32'd1);
        bs.in_valid = 1'b0;
        tick(); clr_s = 1'b0;
        chk("clr2.count",  32'(cnt_s), 32'd0);
        chk("clr2.sticky", 32'(stk_s), 32'd0);

        // Saturating counter
        bs.in_valid = 1'b1; bs.in_data = 32'h8000_0000;
        for (int i = 0; i < 255; i++) tick();
        chk("cnt255", 32'(cnt_s), 32'hFF);
        chk_out("cnt.neg", 1'b1, 16'h8000, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt260", 32'(cnt_s), 32'hFF);
        bs.in_valid = 1'b0;
        tick();

        // Reset with two words buffered
        bs.out_ready = 1'b0;
        bs.in_valid = 1'b1; bs.in_data = 32'h0000_0055;
        tick(); tick();
        bs.in_valid = 1'b0;
        chk("prerst.rdy", 32'(bs.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("inrst.rdy_comb", 32'(bs.in_ready), 32'd0);
        tick();
        chk_out("midrst", 1'b0, 16'h0000, 1'b0);
        chk("midrst.count",  32'(cnt_s), 32'd0);
        chk("midrst.sticky", 32'(stk_s), 32'd0);
        chk("midrst.rdy",    32'(bs.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("afterrst.rdy", 32'(bs.in_ready), 32'd1);
        bs.out_ready = 1'b1;
        tick();
        chk("afterrst.valid", 32'(bs.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/narrow_sat16.md
# narrow_sat16

Streaming narrowing stage that converts 32-bit two's-complement words to 16-bit values. It is the inverse of the datapath's 16→32 sign extension. Each word is checked for representability in 16 bits and either saturated or truncated. A per-word overflow indication plus sticky and counted overflow status are recorded. The block sits between the 32-bit ALU/writeback path and 16-bit consumers such as halfword stores and immediate re-encoding, with valid/ready handshakes and a 2-entry output buffer for backpressure.

## Interface
- SAT, default 1: 1 = clamp out-of-range to 16'h7FFF / 16'h8000; 0 = truncate to in_data[15:0].
- CNT_W, default 8: width of saturating overflow counter.
- clk  input  1  sole clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  signed source word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  16  narrowed word.
- out_ovf  output  1  this out_data was not representable (saturated or truncated).
- ovf_sticky  output  1  any overflow since last clear.
- ovf_count  output  CNT_W  number of overflowed words accepted, saturating at all-ones.
- clr_ovf  input  1  clears ovf_sticky and ovf_count.

## Operation
- Fit test: word fits iff in_data[31:15] all 0 or all 1; ovf = !fit.
- Result: fit → in_data[15:0]; !fit & SAT → in_data[31] ? 16'h8000 : 16'h7FFF; !fit & !SAT → in_data[15:0].
- Accept (push) when in_valid & in_ready; {result, ovf} written to 2-entry FIFO.
- Pop when out_valid & out_ready.
- in_ready = (count < 2) | out_ready-pop-this-cycle is NOT used: in_ready = count < 2 (no combinational ready path through block).
- out_valid = count != 0; out_data/out_ovf = FIFO head.
- Simultaneous push and pop at count 1: count stays 1, order preserved; at count 2 push is blocked.
- Overflow status updates on push of an ovf word: ovf_sticky ← 1, ovf_count ← ovf_count+1 unless all-ones (holds, no wrap).
- clr_ovf same cycle as ovf push: new event wins → ovf_sticky = 1, ovf_count = 1.
- clr_ovf alone: ovf_sticky = 0, ovf_count = 0.
- FIFO count is 0..2; pointers wrap modulo 2.

## Timing
- Reset values: in_ready 1 after reset deasserts (0 while reset high), out_valid 0, out_data 16'h0000, out_ovf 0, ovf_sticky 0, ovf_count 0, FIFO count 0, pointers 0.
- Latency: word pushed at edge N is presented with out_valid=1 after edge N (visible in cycle N+1); no combinational path in_data→out_data.
- Throughput: 1 word/cycle sustained when out_ready held high.
- out_data/out_ovf stable while out_valid & !out_ready.
- Reset mid-stream: buffered words discarded, status cleared, in_ready held 0 during reset.

## Structure
- Package narrow_pkg: IN_W=32, OUT_W=16, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000, typedef struct {logic [15:0] data; logic ovf;} narrow_entry_t.
- Sub-module fifo2: 2-entry synchronous FIFO of narrow_entry_t with push/pop/count; top holds fit logic, saturation mux, status registers.

## Test plan
- Reset then push 32'h0000_1234, 32'hFFFF_8000, 32'h0000_7FFF with out_ready=1 → outputs 16'h1234, 16'h8000, 16'h7FFF, all out_ovf=0, one per cycle, 1-cycle latency.
- SAT=1, push 32'h0000_8000 and 32'hFFFF_7FFF → 16'h7FFF/ovf=1, 16'h8000/ovf=1; ovf_sticky=1, ovf_count=2.
- SAT=0, push 32'h0001_2345 → 16'h2345, out_ovf=1, ovf_count=1.
- out_ready=0, push 3 words → in_ready drops after second push, third held, first output stable; release out_ready → all three emerge in order.
- Push ovf word with clr_ovf=1 same cycle while ovf_count=5 → ovf_count=1, ovf_sticky=1; then clr_ovf alone → 0, 0; 260 ovf pushes → ovf_count holds 8'hFF.
- Assert reset with 2 words buffered → out_valid=0, ovf_count=0 next cycle; in_ready=1 after reset deasserts.
